// File: rtl/nspi_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// nspi_pkg: shared types and width helpers for the nspi link blocks
// Rev 1.0
// ------------------------------------------------------------------
package nspi_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   function automatic int cnt_width(input int spi_size);
      return $clog2(spi_size + 1);
   endfunction

   function automatic int idle_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nspi_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// nspi_sync: two-flop synchronizer with synchronous active-low clear
// Rev 1.0
// ------------------------------------------------------------------
module nspi_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule
`default_nettype wire

// File: rtl/nspi_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// nspi_rx: oversampling multi-lane SPI receiver with valid/ready output
// Rev 1.0
// ------------------------------------------------------------------
module nspi_rx
   import nspi_pkg::*;
#(
   parameter int CHANNEL_NUMBER = 3,
   parameter int SPI_SIZE       = 8,
   parameter int MSB_FIRST      = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      spi_clk,
   input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
   output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER],
   output logic                      data_valid,
   input  logic                      data_ready,
   output logic                      rx_busy,
   output logic                      overrun,
   output logic                      frame_error
);

   localparam int CW = cnt_width(SPI_SIZE);
   localparam int IW = idle_width(TIMEOUT_CYCLES);

   logic [CHANNEL_NUMBER:0]   sync_s;
   logic                      sclk_s;
   logic [CHANNEL_NUMBER-1:0] mosi_s;
   logic                      rise;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idle_q, idle_d;
   logic                prev_q, prev_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                ovr_q, ovr_d;
   logic                ferr_q, ferr_d;
   logic [SPI_SIZE-1:0] shift_q [CHANNEL_NUMBER];
   logic [SPI_SIZE-1:0] shift_d [CHANNEL_NUMBER];
   logic [SPI_SIZE-1:0] data_q  [CHANNEL_NUMBER];
   logic [SPI_SIZE-1:0] data_d  [CHANNEL_NUMBER];

   nspi_sync #(
      .WIDTH(CHANNEL_NUMBER + 1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  ({spi_clk, spi_mosi}),
      .q  (sync_s)
   );

   assign sclk_s = sync_s[CHANNEL_NUMBER];
   assign mosi_s = sync_s[CHANNEL_NUMBER-1:0];
   assign rise   = sclk_s & ~prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idle_d  = idle_q;
      prev_d  = sclk_s;
      valid_d = valid_q;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
      shift_d = shift_q;
      data_d  = data_q;

      if (valid_q && data_ready) begin
         valid_d = 1'b0;
      end

      if (rise) begin
         for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            shift_d[c] = (MSB_FIRST != 0) ? {shift_q[c][SPI_SIZE-2:0], mosi_s[c]}
                                          : {mosi_s[c], shift_q[c][SPI_SIZE-1:1]};
         end
      end

      case (state_q)
         IDLE: begin
            idle_d = '0;
            if (rise) begin
               cnt_d   = CW'(1);
               state_d = RECEIVE;
            end
         end
         RECEIVE: begin
            if (rise) begin
               idle_d = '0;
               if (cnt_q == CW'(SPI_SIZE - 1)) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  // a word set that cannot be handed over is dropped, the held one wins
                  if (!valid_q || data_ready) begin
                     data_d  = shift_d;
                     valid_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               idle_d = idle_q + IW'(1);
               if (idle_d == IW'(TIMEOUT_CYCLES)) begin
                  ferr_d  = 1'b1;
                  cnt_d   = '0;
                  idle_d  = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RECEIVE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idle_q  <= '0;
         prev_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
         shift_q <= '{default: '0};
         data_q  <= '{default: '0};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idle_q  <= idle_d;
         prev_q  <= prev_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
         shift_q <= shift_d;
         data_q  <= data_d;
      end
   end

   assign data_out    = data_q;
   assign data_valid  = valid_q;
   assign rx_busy     = busy_q;
   assign overrun     = ovr_q;
   assign frame_error = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_nspi_rx.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_nspi_rx: MSB-first and LSB-first receivers against a bit-stream model
// Rev 1.0
// ------------------------------------------------------------------
module tb_nspi_rx;

   localparam int CH = 3;
   localparam int S  = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          spi_clk;
   logic [CH-1:0] spi_mosi;
   logic          dir_ready;
   logic          rnd_ready;
   logic          rand_mode;
   logic          data_ready;

   logic [S-1:0]  dout_m [CH];
   logic [S-1:0]  dout_l [CH];
   logic          valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;

   assign data_ready = rand_mode ? rnd_ready : dir_ready;

   always #5 clk = ~clk;

   nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(S), .MSB_FIRST(1), .TIMEOUT_CYCLES(TO)) u_msb (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .data_out(dout_m), .data_valid(valid_m), .data_ready(data_ready),
      .rx_busy(busy_m), .overrun(ovr_m), .frame_error(ferr_m));

   nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(S), .MSB_FIRST(0), .TIMEOUT_CYCLES(TO)) u_lsb (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .data_out(dout_l), .data_valid(valid_l), .data_ready(data_ready),
      .rx_busy(busy_l), .overrun(ovr_l), .frame_error(ferr_l));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: spi_clk/mosi as driven, seen two clk edges late; words built from the bit list
   bit            hc [4];
   logic [CH-1:0] hm [4];
   logic [CH-1:0] m_bits [S];
   int            m_n = 0, m_idle = 0;
   bit            m_busy = 0, m_valid = 0, m_ovr = 0, m_ferr = 0, armed = 0;
   logic [S-1:0]  m_dm [CH];
   logic [S-1:0]  m_dl [CH];

   logic [S-1:0]  cap_m [CH];
   logic [S-1:0]  cap_l [CH];
   int            cap_cnt = 0, ovr_cnt = 0, ferr_cnt = 0;

   always @(posedge clk) begin : model
      bit rise, accept, loaded;
      if (armed && valid_m && data_ready) begin
         cap_m = dout_m;
         cap_l = dout_l;
         cap_cnt++;
      end
      if (armed && ovr_m)  ovr_cnt++;
      if (armed && ferr_m) ferr_cnt++;
      for (int i = 3; i > 0; i--) begin
         hc[i] = hc[i-1];
         hm[i] = hm[i-1];
      end
      hc[0] = spi_clk;
      hm[0] = spi_mosi;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            hc[i] = 1'b0;
            hm[i] = '0;
         end
         m_n = 0; m_idle = 0; m_busy = 0; m_valid = 0; m_ovr = 0; m_ferr = 0;
         m_dm = '{default: '0};
         m_dl = '{default: '0};
         armed = 1;
      end else begin
         rise   = hc[2] && !hc[3];
         accept = m_valid && data_ready;
         loaded = 0;
         m_ovr  = 0;
         m_ferr = 0;
         if (rise) begin
            m_bits[m_n] = hm[2];
            m_n++;
            m_idle = 0;
            m_busy = 1;
            if (m_n == S) begin
               m_n    = 0;
               m_busy = 0;
               if (!m_valid || data_ready) begin
                  for (int c = 0; c < CH; c++) begin
                     int wm, wl;
                     wm = 0;
                     wl = 0;
                     for (int j = 0; j < S; j++) begin
                        wm = wm + (int'(m_bits[j][c]) << (S - 1 - j));
                        wl = wl + (int'(m_bits[j][c]) << j);
                     end
                     m_dm[c] = S'(wm);
                     m_dl[c] = S'(wl);
                  end
                  m_valid = 1;
                  loaded  = 1;
               end else begin
                  m_ovr = 1;
               end
            end
         end else if (m_busy) begin
            m_idle++;
            if (m_idle == TO) begin
               m_ferr = 1;
               m_busy = 0;
               m_n    = 0;
               m_idle = 0;
            end
         end
         if (accept && !loaded) m_valid = 0;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("valid_m", 32'(valid_m), 32'(m_valid));
         chk("valid_l", 32'(valid_l), 32'(m_valid));
         chk("busy_m",  32'(busy_m),  32'(m_busy));
         chk("busy_l",  32'(busy_l),  32'(m_busy));
         chk("ovr_m",   32'(ovr_m),   32'(m_ovr));
         chk("ovr_l",   32'(ovr_l),   32'(m_ovr));
         chk("ferr_m",  32'(ferr_m),  32'(m_ferr));
         chk("ferr_l",  32'(ferr_l),  32'(m_ferr));
         for (int c = 0; c < CH; c++) begin
            chk("dout_m", 32'(dout_m[c]), 32'(m_dm[c]));
            chk("dout_l", 32'(dout_l[c]), 32'(m_dl[c]));
         end
      end
   end

   always @(negedge clk) rnd_ready = 1'($urandom_range(0, 1));

   // Words go out MSB first on the wire; rp raises data_ready exactly on the completion edge
   task automatic send_word(input logic [S-1:0] w0, input logic [S-1:0] w1,
                            input logic [S-1:0] w2, input int nbits, input int half,
                            input bit rp);
      for (int j = 0; j < nbits; j++) begin
         spi_mosi = {w2[S-1-j], w1[S-1-j], w0[S-1-j]};
         spi_clk  = 1'b0;
         repeat (half) @(negedge clk);
         spi_clk = 1'b1;
         if (rp && j == nbits - 1) begin
            repeat (2) @(negedge clk);
            dir_ready = 1'b1;
            @(negedge clk);
            dir_ready = 1'b0;
            repeat (half - 3) @(negedge clk);
         end else begin
            repeat (half) @(negedge clk);
         end
      end
      spi_clk = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int oc, fc, cc;
      rst = 1'b0; spi_clk = 1'b0; spi_mosi = '0;
      dir_ready = 1'b0; rand_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(valid_m), 32'h0);
      chk("rst_busy",  32'(busy_m),  32'h0);
      chk("rst_dout",  32'(dout_m[1]), 32'h0);
      rst = 1'b1;

      repeat (12) begin
         @(negedge clk);
         spi_mosi = ~spi_mosi;
      end
      repeat (3) @(negedge clk);
      chk("idle_valid", 32'(valid_m), 32'h0);
      chk("idle_busy",  32'(busy_m),  32'h0);
      chk("idle_flags", 32'(ovr_cnt + ferr_cnt), 32'h0);

      dir_ready = 1'b1;
      cc = cap_cnt;
      send_word(8'hA5, 8'h3C, 8'hFF, S, 4, 0);
      repeat (4) @(negedge clk);
      chk("single_cnt", 32'(cap_cnt - cc), 32'h1);
      chk("single_ch0", 32'(cap_m[0]), 32'hA5);
      chk("single_ch1", 32'(cap_m[1]), 32'h3C);
      chk("single_ch2", 32'(cap_m[2]), 32'hFF);
      chk("single_drop", 32'(valid_m), 32'h0);

      send_word(8'h80, 8'h00, 8'h00, S, 4, 0);
      repeat (4) @(negedge clk);
      chk("lsb_first", 32'(cap_l[0]), 32'h01);
      chk("msb_first", 32'(cap_m[0]), 32'h80);

      dir_ready = 1'b0;
      oc = ovr_cnt;
      send_word(8'h11, 8'h11, 8'h11, S, 4, 0);
      send_word(8'h22, 8'h22, 8'h22, S, 4, 0);
      repeat (4) @(negedge clk);
      chk("ovr_data",  32'(dout_m[0]), 32'h11);
      chk("ovr_valid", 32'(valid_m), 32'h1);
      chk("ovr_pulse", 32'(ovr_cnt - oc), 32'h1);
      dir_ready = 1'b1;
      @(negedge clk);
      dir_ready = 1'b0;
      @(negedge clk);
      chk("ovr_accept", 32'(valid_m), 32'h0);

      oc = ovr_cnt;
      send_word(8'h11, 8'h11, 8'h11, S, 4, 0);
      send_word(8'h22, 8'h22, 8'h22, S, 4, 1);
      repeat (4) @(negedge clk);
      chk("simul_data",  32'(dout_m[0]), 32'h22);
      chk("simul_valid", 32'(valid_m), 32'h1);
      chk("simul_novr",  32'(ovr_cnt - oc), 32'h0);
      dir_ready = 1'b1;

      fc = ferr_cnt;
      send_word(8'hFF, 8'h00, 8'hFF, 3, 4, 0);
      repeat (80) @(negedge clk);
      chk("tmo_pulse", 32'(ferr_cnt - fc), 32'h1);
      chk("tmo_busy",  32'(busy_m), 32'h0);
      send_word(8'h5A, 8'h5A, 8'h5A, S, 4, 0);
      repeat (4) @(negedge clk);
      chk("tmo_next", 32'(cap_m[0]), 32'h5A);

      fc = ferr_cnt;
      oc = ovr_cnt;
      send_word(8'hFF, 8'hFF, 8'hFF, 5, 4, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mrst_busy",  32'(busy_m), 32'h0);
      chk("mrst_flags", 32'((ferr_cnt - fc) + (ovr_cnt - oc)), 32'h0);
      send_word(8'hC3, 8'h5A, 8'h3C, S, 4, 0);
      repeat (4) @(negedge clk);
      chk("mrst_next", 32'(cap_m[0]), 32'hC3);

      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int half, gap;
         half = int'($urandom_range(2, 5));
         if ($urandom_range(0, 7) == 0) begin
            send_word(S'($urandom), S'($urandom), S'($urandom),
                      int'($urandom_range(1, S - 1)), half, 0);
            repeat (TO + 6) @(negedge clk);
         end else begin
            send_word(S'($urandom), S'($urandom), S'($urandom), S, half, 0);
         end
         gap = int'($urandom_range(0, 6));
         repeat (gap) begin
            @(negedge clk);
            spi_mosi = CH'($urandom);
         end
      end
      repeat (10) @(negedge clk);
      rand_mode = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
